// File: rtl/delay_scale_pkg.sv
// Shared constants, types and the output saturation helper for the delay-and-scale path.
package delay_scale_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned DELAY_W    = 8;
  localparam int unsigned DEPTH      = 2 ** DELAY_W;
  localparam int unsigned SCALE_W    = 5;
  localparam int unsigned SCALE_FRAC = 3;
  localparam int unsigned MAG_W      = SCALE_W - 1;
  // One spare bit over the raw product so negating the most negative value cannot wrap.
  localparam int unsigned ACC_W      = SAMPLE_W + MAG_W + 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [DELAY_W-1:0]         addr_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (SAMPLE_W - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (SAMPLE_W - 1)));

  function automatic sample_t saturate(acc_t v);
    if (v > SAT_MAX) begin
      return sample_t'(SAT_MAX[SAMPLE_W-1:0]);
    end else if (v < SAT_MIN) begin
      return sample_t'(SAT_MIN[SAMPLE_W-1:0]);
    end
    return sample_t'(v[SAMPLE_W-1:0]);
  endfunction

endpackage

// File: rtl/delay_and_scale_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no storage reset.
module delay_ram
  import delay_scale_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [DELAY_W-1:0]  wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [DELAY_W-1:0]  rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/delay_and_scale.sv
// Per-sample delay line followed by a sign-magnitude Q1.3 gain with saturation.
module delay_and_scale
  import delay_scale_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       ready_in,
  input  logic [DELAY_W-1:0]         delay_in,
  input  logic [SCALE_W-1:0]         scale_in,
  input  logic signed [SAMPLE_W-1:0] signal_in,
  output logic signed [SAMPLE_W-1:0] signal_out,
  output logic                       done_out
);

  addr_t   wptr_q, wptr_d;
  addr_t   fill_q, fill_d;
  addr_t   rd_addr;

  logic    s1_valid_q;
  logic    s1_zero_q;
  logic    s1_bypass_q;
  sample_t s1_bypass_data_q;
  logic    s1_sign_q;
  logic [MAG_W-1:0] s1_mag_q;

  logic [SAMPLE_W-1:0] rd_data;
  sample_t delayed;
  acc_t    product;
  acc_t    scaled;
  sample_t result;

  // Read and write share the same edge; addresses only collide at delay 0, which is bypassed.
  assign rd_addr = wptr_q - delay_in;

  delay_ram u_ram (
    .clk     (clk_in),
    .wr_en   (ready_in),
    .wr_addr (wptr_q),
    .wr_data (signal_in),
    .rd_en   (ready_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (ready_in) begin
      wptr_d = wptr_q + 8'd1;
      if (fill_q != '1) begin
        fill_d = fill_q + 8'd1;
      end
    end
  end

  always_comb begin
    delayed = '0;
    if (!s1_zero_q) begin
      delayed = s1_bypass_q ? s1_bypass_data_q : sample_t'(rd_data);
    end
    product = acc_t'(delayed) * acc_t'($signed({1'b0, s1_mag_q}));
    scaled  = product >>> SCALE_FRAC;
    if (s1_sign_q) begin
      scaled = -scaled;
    end
    result = saturate(scaled);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wptr_q           <= '0;
      fill_q           <= '0;
      s1_valid_q       <= 1'b0;
      s1_zero_q        <= 1'b0;
      s1_bypass_q      <= 1'b0;
      s1_bypass_data_q <= '0;
      s1_sign_q        <= 1'b0;
      s1_mag_q         <= '0;
      signal_out       <= '0;
      done_out         <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      s1_valid_q <= ready_in;
      if (ready_in) begin
        s1_zero_q        <= fill_q < delay_in;
        s1_bypass_q      <= delay_in == '0;
        s1_bypass_data_q <= signal_in;
        s1_sign_q        <= scale_in[SCALE_W-1];
        s1_mag_q         <= scale_in[MAG_W-1:0];
      end
      done_out <= s1_valid_q;
      if (s1_valid_q) begin
        signal_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_delay_and_scale.sv
// Randomised and directed bench for delay_and_scale against a sample-history reference model.
module tb_delay_and_scale;

  logic               clk;
  logic               reset_n;
  logic               ready;
  logic [7:0]         delay;
  logic [4:0]         scale;
  logic signed [15:0] sig_in;
  logic signed [15:0] sig_out;
  logic               done;

  int n_cmp;
  int n_bad;
  int cyc;

  typedef struct {
    int due;
    int val;
  } pend_t;

  int    hist[$];
  pend_t pend[$];
  int    exp_out;
  logic signed [15:0] exp_s;
  logic  exp_done;

  delay_and_scale dut (
    .clk_in     (clk),
    .reset_in   (reset_n),
    .ready_in   (ready),
    .delay_in   (delay),
    .scale_in   (scale),
    .signal_in  (sig_in),
    .signal_out (sig_out),
    .done_out   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gain from first principles: magnitude/8 rounded toward -inf, optional negation, clamp.
  function automatic int ref_gain(int x, int s);
    int mag;
    int p;
    mag = s % 16;
    p = (x * mag) >>> 3;
    if (s >= 16) p = -p;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p;
  endfunction

  task automatic tick(input bit rst_n, input bit rdy, input int d, input int s, input int x);
    int n;
    int dl;
    reset_n = rst_n;
    ready   = rdy;
    delay   = d[7:0];
    scale   = s[4:0];
    sig_in  = x[15:0];
    if (!rst_n) begin
      hist.delete();
      pend.delete();
    end else if (rdy) begin
      n = hist.size();
      if (d == 0) dl = x;
      else if (n < d) dl = 0;
      else dl = hist[n-d];
      pend.push_back('{cyc + 2, ref_gain(dl, s)});
      hist.push_back(x);
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_done = 1'b0;
    if (!rst_n) begin
      exp_out = 0;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_done = 1'b1;
      exp_out  = pend[0].val;
      void'(pend.pop_front());
    end
    exp_s = exp_out[15:0];
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (done !== exp_done) begin
        n_bad++;
        $display("FAIL reset_done cyc=%0d got=%b want=%b", cyc, done, exp_done);
      end
      n_cmp++;
      if (sig_out !== exp_s) begin
        n_bad++;
        $display("FAIL reset_out cyc=%0d got=%0d want=%0d", cyc, sig_out, exp_s);
      end
      tick(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_ramp();
    tick(0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      for (int c = 0; c < 128; c++) begin
        tick(1, c == 0, 10, 24, k);
        n_cmp++;
        if (done !== exp_done) begin
          n_bad++;
          $display("FAIL ramp_done k=%0d c=%0d got=%b want=%b", k, c, done, exp_done);
        end
        n_cmp++;
        if (sig_out !== exp_s) begin
          n_bad++;
          $display("FAIL ramp_out k=%0d c=%0d got=%0d want=%0d", k, c, sig_out, exp_s);
        end
      end
    end
  endtask

  task automatic test_bypass();
    int sc[2];
    int xs[2];
    sc[0] = 8; xs[0] = 1234;
    sc[1] = 4; xs[1] = -3;
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1, c == 0, 0, sc[t], xs[t]);
        n_cmp++;
        if (done !== exp_done || sig_out !== exp_s) begin
          n_bad++;
          $display("FAIL bypass t=%0d c=%0d got=%b/%0d want=%b/%0d",
                   t, c, done, sig_out, exp_done, exp_s);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int sc[5];
    int xs[5];
    sc[0] = 15; xs[0] = 30000;
    sc[1] = 15; xs[1] = -30000;
    sc[2] = 24; xs[2] = -32768;
    sc[3] = 16; xs[3] = 12345;
    sc[4] = 16; xs[4] = -777;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 3; c++) begin
        tick(1, c == 0, 0, sc[t], xs[t]);
        n_cmp++;
        if (done !== exp_done || sig_out !== exp_s) begin
          n_bad++;
          $display("FAIL sat t=%0d c=%0d got=%b/%0d want=%b/%0d",
                   t, c, done, sig_out, exp_done, exp_s);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(0, 0, 0, 0, 0);
    for (int n = 0; n < 603; n++) begin
      tick(1, n < 600, 255, 8, n);
      n_cmp++;
      if (done !== exp_done || sig_out !== exp_s) begin
        n_bad++;
        $display("FAIL b2b n=%0d got=%b/%0d want=%b/%0d", n, done, sig_out, exp_done, exp_s);
      end
    end
  endtask

  task automatic test_reset_midstream();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 3, 8, 500 + i);
    tick(1, 1, 3, 8, 600);
    tick(0, 1, 3, 8, 601);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (done !== 1'b0 || sig_out !== 16'sd0) begin
        n_bad++;
        $display("FAIL midrst c=%0d got=%b/%0d want=0/0", c, done, sig_out);
      end
      tick(1, 0, 3, 8, 0);
    end
    for (int i = 0; i < 9; i++) begin
      tick(1, i < 6, 3, 8, 100 + i);
      n_cmp++;
      if (done !== exp_done || sig_out !== exp_s) begin
        n_bad++;
        $display("FAIL midrst_after i=%0d got=%b/%0d want=%b/%0d",
                 i, done, sig_out, exp_done, exp_s);
      end
    end
  endtask

  task automatic test_random();
    int d;
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      tick(1, $urandom_range(0, 9) < 7, d, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 65535)) - 32768);
      n_cmp++;
      if (done !== exp_done || sig_out !== exp_s) begin
        n_bad++;
        $display("FAIL random i=%0d got=%b/%0d want=%b/%0d", i, done, sig_out, exp_done, exp_s);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    exp_out  = 0;
    exp_s    = '0;
    exp_done = 1'b0;
    reset_n  = 1'b0;
    ready    = 1'b0;
    delay    = '0;
    scale    = '0;
    sig_in   = '0;
    test_reset();
    test_ramp();
    test_bypass();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
